// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and defaults for the MEM pipeline stage
package mem_stage_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data-memory request/ready bus between MEM stage and memory
interface mem_stage_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  ready;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ready
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ready
    );
endinterface

// File: rtl/mem_stage_dmem_handshake.sv
// rtl/mem_stage_dmem_handshake.sv - data-memory access FSM with timeout, stall and sticky error
module dmem_handshake
    import mem_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int TO_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] access_addr,
    input  logic [DATA_WIDTH-1:0] store_data,
    mem_stage_if.master           dmem,
    output logic                  stall,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] load_data
);

    state_t                state;
    state_t                state_n;
    logic [TO_WIDTH-1:0]   cnt;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  mem_op;
    logic                  timeout;
    logic                  issue;
    logic                  done;

    assign mem_op  = mem_read | mem_write;
    // ready in the final wait cycle beats the timeout
    assign timeout = (state == BUSY) && !dmem.ready && (cnt == TO_WIDTH'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        stall   = 1'b0;
        issue   = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    state_n = BUSY;
                    stall   = 1'b1;
                    issue   = 1'b1;
                end
            end
            BUSY: begin
                if (dmem.ready || timeout) begin
                    state_n = IDLE;
                    done    = 1'b1;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem.req   <= 1'b0;
            dmem.we    <= 1'b0;
            dmem.addr  <= '0;
            dmem.wdata <= '0;
            cnt        <= '0;
            rdata_q    <= '0;
            err        <= 1'b0;
        end else if (issue) begin
            dmem.req   <= 1'b1;
            dmem.we    <= mem_write;
            dmem.addr  <= access_addr;
            dmem.wdata <= store_data;
            cnt        <= '0;
        end else if (done) begin
            dmem.req <= 1'b0;
            if (!dmem.we) rdata_q <= dmem.ready ? dmem.rdata : '0;
            if (timeout)  err     <= 1'b1;
        end else if (state == BUSY) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Completion cycle bypasses the bus so MEM/WB captures the load without an extra cycle
    assign load_data = (state == BUSY) ? (dmem.ready ? dmem.rdata : '0) : rdata_q;

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM stage: memory access, branch resolution, M forwarding and MEM/WB register
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int IMM8_WIDTH = 8,
    parameter int REG_WIDTH  = 4,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int TO_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] PCM_i,
    input  logic [DATA_WIDTH-1:0] WriteDataM_i,
    input  logic [IMM8_WIDTH-1:0] imm8M_i,
    input  logic [REG_WIDTH-1:0]  WriteRegM_i,
    input  logic [DATA_WIDTH-1:0] alu_outM_i,
    input  logic                  RegWriteM_i,
    input  logic                  BranchM_i,
    input  logic                  MemReadM_i,
    input  logic                  MemWriteM_i,
    input  logic                  MemToRegM_i,
    input  logic                  MovM_i,
    mem_stage_if.master           dmem,
    output logic                  stall_mem_o,
    output logic                  mem_err_o,
    output logic                  PCSrcM_o,
    output logic [ADDR_WIDTH-1:0] PCBranchM_o,
    output logic [DATA_WIDTH-1:0] WBResultM_o,
    output logic [DATA_WIDTH-1:0] ReadDataW_o,
    output logic [DATA_WIDTH-1:0] ALUResultW_o,
    output logic [REG_WIDTH-1:0]  WriteRegW_o,
    output logic                  RegWriteW_o,
    output logic                  MemToRegW_o
);

    logic [DATA_WIDTH-1:0]        load_data;
    logic signed [IMM8_WIDTH-1:0] imm_s;

    dmem_handshake #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .TIMEOUT    (TIMEOUT),
        .TO_WIDTH   (TO_WIDTH)
    ) u_handshake (
        .clk         (clk),
        .rst         (rst),
        .mem_read    (MemReadM_i),
        .mem_write   (MemWriteM_i),
        .access_addr (alu_outM_i[ADDR_WIDTH-1:0]),
        .store_data  (WriteDataM_i),
        .dmem        (dmem),
        .stall       (stall_mem_o),
        .err         (mem_err_o),
        .load_data   (load_data)
    );

    // Load data is deliberately not forwarded from M; load-use is resolved by the hazard unit
    assign WBResultM_o = MovM_i ? DATA_WIDTH'(imm8M_i) : alu_outM_i;
    assign PCSrcM_o    = BranchM_i & (alu_outM_i == '0);
    assign imm_s       = imm8M_i;
    assign PCBranchM_o = PCM_i + ADDR_WIDTH'(imm_s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWriteW_o  <= 1'b0;
            MemToRegW_o  <= 1'b0;
            WriteRegW_o  <= '0;
            ReadDataW_o  <= '0;
            ALUResultW_o <= '0;
        end else if (stall_mem_o) begin
            RegWriteW_o <= 1'b0;
            MemToRegW_o <= 1'b0;
        end else begin
            RegWriteW_o  <= RegWriteM_i;
            MemToRegW_o  <= MemToRegM_i;
            WriteRegW_o  <= WriteRegM_i;
            ReadDataW_o  <= MemReadM_i ? load_data : '0;
            ALUResultW_o <= WBResultM_o;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage with randomized instructions and memory latency
module tb_mem_stage;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] wd;
        logic [7:0]  imm;
        logic [3:0]  wreg;
        logic [15:0] alu;
        logic        rw, br, mr, mw, m2r, mov;
        int          lat;
        logic [15:0] rdata;
    } ins_t;

    typedef struct {
        logic [15:0] wb;
        logic        pcsrc;
        logic [7:0]  pcb;
        logic        rw, m2r;
        logic [3:0]  wreg;
        logic [15:0] rd;
        logic        err;
        int          stalls;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  pcm = '0;
    logic [15:0] wdm = '0;
    logic [7:0]  immm = '0;
    logic [3:0]  wregm = '0;
    logic [15:0] alum = '0;
    logic        rwm = 0, brm = 0, mrm = 0, mwm = 0, m2rm = 0, movm = 0;
    logic        stall, err, pcsrc, rw_w, m2r_w;
    logic [7:0]  pcb;
    logic [15:0] wb, rd_w, alu_w;
    logic [3:0]  wreg_w;

    int          n_checks = 0;
    int          n_err = 0;
    exp_t        q[$];
    bit          mon_en = 1'b0;
    logic        err_model = 1'b0;
    int          r_lat = 0;
    logic [15:0] r_rdata = '0;
    logic [7:0]  r_addr = '0;
    logic        r_we = 1'b0;
    logic [15:0] r_wdata = '0;

    always #5 clk = ~clk;

    mem_stage_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dmem ();

    mem_stage dut (
        .clk          (clk),
        .rst          (rst),
        .PCM_i        (pcm),
        .WriteDataM_i (wdm),
        .imm8M_i      (immm),
        .WriteRegM_i  (wregm),
        .alu_outM_i   (alum),
        .RegWriteM_i  (rwm),
        .BranchM_i    (brm),
        .MemReadM_i   (mrm),
        .MemWriteM_i  (mwm),
        .MemToRegM_i  (m2rm),
        .MovM_i       (movm),
        .dmem         (dmem.master),
        .stall_mem_o  (stall),
        .mem_err_o    (err),
        .PCSrcM_o     (pcsrc),
        .PCBranchM_o  (pcb),
        .WBResultM_o  (wb),
        .ReadDataW_o  (rd_w),
        .ALUResultW_o (alu_w),
        .WriteRegW_o  (wreg_w),
        .RegWriteW_o  (rw_w),
        .MemToRegW_o  (m2r_w)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory responder: ready after r_lat wait cycles of req; random ready noise while idle
    initial begin
        int wc;
        wc = 0;
        dmem.ready = 1'b0;
        dmem.rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            dmem.rdata = 16'($urandom);
            if (!dmem.req) begin
                wc = 0;
                dmem.ready = 1'($urandom_range(0, 1));
            end else begin
                dmem.ready = 1'b0;
                if (wc == r_lat) begin
                    dmem.ready = 1'b1;
                    dmem.rdata = r_rdata;
                    chk("bus_addr", 32'(dmem.addr), 32'(r_addr));
                    chk("bus_we", 32'(dmem.we), 32'(r_we));
                    if (r_we) chk("bus_wdata", 32'(dmem.wdata), 32'(r_wdata));
                end
                wc++;
            end
        end
    end

    // Monitor: a non-stall cycle completes the oldest instruction; MEM/WB is checked one cycle later
    initial begin
        exp_t pe;
        bit   pend, bub;
        int   st;
        pend = 0; bub = 0; st = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                pend = 0; bub = 0; st = 0;
            end else begin
                if (pend) begin
                    chk("RegWriteW", 32'(rw_w), 32'(pe.rw));
                    chk("MemToRegW", 32'(m2r_w), 32'(pe.m2r));
                    chk("WriteRegW", 32'(wreg_w), 32'(pe.wreg));
                    chk("ReadDataW", 32'(rd_w), 32'(pe.rd));
                    chk("ALUResultW", 32'(alu_w), 32'(pe.wb));
                    chk("mem_err", 32'(err), 32'(pe.err));
                    chk("req_dropped", 32'(dmem.req), 32'd0);
                    pend = 0;
                end
                if (bub) begin
                    chk("bubble_RegWriteW", 32'(rw_w), 32'd0);
                    chk("bubble_MemToRegW", 32'(m2r_w), 32'd0);
                    bub = 0;
                end
                if (stall) begin
                    bub = 1;
                    st++;
                end else if (q.size() != 0) begin
                    pe = q.pop_front();
                    chk("WBResultM", 32'(wb), 32'(pe.wb));
                    chk("PCSrcM", 32'(pcsrc), 32'(pe.pcsrc));
                    chk("PCBranchM", 32'(pcb), 32'(pe.pcb));
                    chk("stall_cycles", 32'(st), 32'(pe.stalls));
                    st = 0;
                    pend = 1;
                end
            end
        end
    end

    task automatic run_ins(input ins_t i);
        exp_t e;
        bit   to;
        int   off;
        int   lim;
        @(posedge clk);
        #1;
        pcm = i.pc; wdm = i.wd; immm = i.imm; wregm = i.wreg; alum = i.alu;
        rwm = i.rw; brm = i.br; mrm = i.mr; mwm = i.mw; m2rm = i.m2r; movm = i.mov;
        r_lat = i.lat; r_rdata = i.rdata; r_addr = i.alu[7:0]; r_we = i.mw; r_wdata = i.wd;
        to        = (i.mr || i.mw) && (i.lat > 15);
        off       = (i.imm >= 8'd128) ? int'(i.imm) - 256 : int'(i.imm);
        err_model = err_model | to;
        e.wb      = i.mov ? {8'h00, i.imm} : i.alu;
        e.pcsrc   = i.br && (i.alu == 16'd0);
        e.pcb     = 8'((int'(i.pc) + off + 256) % 256);
        e.rw      = i.rw;
        e.m2r     = i.m2r;
        e.wreg    = i.wreg;
        e.rd      = i.mr ? (to ? 16'd0 : i.rdata) : 16'd0;
        e.err     = err_model;
        e.stalls  = (i.mr || i.mw) ? (to ? 16 : i.lat + 1) : 0;
        q.push_back(e);
        lim = 0;
        do begin
            @(negedge clk);
            lim++;
        end while (stall && lim < 40);
        if (stall) begin
            n_checks++;
            n_err++;
            $display("FAIL completion_wait: stall still high after %0d cycles", lim);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        rwm = 0; brm = 0; mrm = 0; mwm = 0; m2rm = 0; movm = 0;
    endtask

    function automatic ins_t mk(input logic [15:0] alu, input logic mr, input logic mw, input int lat,
                                input logic [15:0] rdata);
        ins_t i;
        i.pc = 8'($urandom); i.wd = 16'($urandom); i.imm = 8'($urandom); i.wreg = 4'($urandom);
        i.alu = alu; i.rw = 1'($urandom); i.br = 0; i.mr = mr; i.mw = mw;
        i.m2r = mr; i.mov = 0; i.lat = lat; i.rdata = rdata;
        return i;
    endfunction

    initial begin
        ins_t i;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req", 32'(dmem.req), 0);
        chk("rst_we", 32'(dmem.we), 0);
        chk("rst_addr", 32'(dmem.addr), 0);
        chk("rst_wdata", 32'(dmem.wdata), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_W", {rd_w, alu_w}, 0);
        chk("rst_Wctl", {wreg_w, rw_w, m2r_w}, 0);
        mon_en = 1'b1;

        i = mk(16'h0012, 1, 0, 2, 16'hBEEF); i.wreg = 4'd3; i.rw = 1; run_ins(i);
        i = mk(16'h0040, 0, 1, 0, 16'h0); i.wd = 16'h1234; i.rw = 0; i.m2r = 0; run_ins(i);
        i = mk(16'h0077, 1, 0, 1, 16'hC0DE); run_ins(i);
        i = mk(16'h0021, 1, 0, 15, 16'h4321); run_ins(i);
        i = mk(16'h0022, 1, 0, 255, 16'hDEAD); i.rw = 1; run_ins(i);
        i = mk(16'h0000, 0, 0, 0, 16'h0); i.br = 1; i.pc = 8'hFE; i.imm = 8'h04; run_ins(i);
        i = mk(16'h0001, 0, 0, 0, 16'h0); i.br = 1; i.pc = 8'h10; i.imm = 8'hF0; run_ins(i);
        i = mk(16'h9999, 0, 0, 0, 16'h0); i.mov = 1; i.imm = 8'hA5; run_ins(i);
        i = mk(16'h0050, 0, 1, 255, 16'h0); run_ins(i);

        for (int n = 0; n < 150; n++) begin
            int k;
            k = $urandom_range(0, 9);
            i = mk(16'($urandom), k < 3, (k >= 3 && k < 6), $urandom_range(0, 4), 16'($urandom));
            if (k == 6) i.lat = ($urandom_range(0, 1) == 0) ? 15 : 16;
            if (k < 3 && $urandom_range(0, 7) == 0) i.lat = 255;
            if (k >= 7) begin
                i.br  = 1'($urandom);
                i.mov = 1'($urandom);
                if ($urandom_range(0, 2) == 0) i.alu = 16'd0;
            end
            run_ins(i);
        end

        idle();
        @(negedge clk);
        #1 mon_en = 1'b0;

        @(posedge clk);
        #1;
        mrm = 1; alum = 16'h0033; r_lat = 255; r_addr = 8'h33; r_we = 0;
        repeat (4) @(negedge clk);
        chk("midbusy_req", 32'(dmem.req), 1);
        chk("midbusy_stall", 32'(stall), 1);
        chk("midbusy_err", 32'(err), 32'(err_model));
        #2;
        rst = 1'b1;
        mrm = 0;
        #1;
        chk("async_rst_req", 32'(dmem.req), 0);
        chk("async_rst_stall", 32'(stall), 0);
        chk("async_rst_err", 32'(err), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        err_model = 1'b0;
        mon_en = 1'b1;
        i = mk(16'h0044, 1, 0, 1, 16'h5A5A); i.rw = 1; run_ins(i);
        idle();
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
